// File: rtl/bka_pipe_adder.sv
// Three-stage pipelined Brent-Kung adder with valid/ready handshake and a global stall.
// Define BKA_OVF_EN to add the registered signed-overflow output ovf.
module bka_pipe_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
`ifdef BKA_OVF_EN
  output logic             ovf,
`endif
  output logic             cout
);

  localparam int L = $clog2(WIDTH);

  logic             w_stall;
  logic             w_adv;

  logic             r1_v, r2_v, r3_v;
  logic [WIDTH-1:0] r1_g, r1_p;
  logic             r1_cin;
  logic [WIDTH-1:0] r2_g, r2_gp, r2_p;
  logic             r2_cin;
  logic [WIDTH-1:0] r3_s;
  logic             r3_cout;
`ifdef BKA_OVF_EN
  logic             r3_ovf;
`endif

  logic [WIDTH-1:0] w_ug [L+1];
  logic [WIDTH-1:0] w_up [L+1];
  logic [WIDTH-1:0] w_dg [L];
  logic [WIDTH:0]   w_c;
  logic [WIDTH-1:0] w_sum;

  // The whole pipeline freezes only when a finished result is not taken.
  assign w_stall  = r3_v & ~out_ready;
  assign w_adv    = ~w_stall;
  assign in_ready = w_adv;

  // Up-sweep; cin is folded into bit 0 so every G[i:0] is the carry into bit i+1.
  always_comb begin
    w_ug[0]    = r1_g;
    w_ug[0][0] = r1_g[0] | (r1_p[0] & r1_cin);
    w_up[0]    = r1_p;
    for (int l = 0; l < L; l++) begin
      w_ug[l+1] = w_ug[l];
      w_up[l+1] = w_up[l];
      for (int i = (2 << l) - 1; i < WIDTH; i += (2 << l)) begin
        w_ug[l+1][i] = w_ug[l][i] | (w_up[l][i] & w_ug[l][i - (1 << l)]);
        w_up[l+1][i] = w_up[l][i] & w_up[l][i - (1 << l)];
      end
    end
  end

  // Down-sweep; each node's group P is still its up-sweep value when it is combined.
  always_comb begin
    w_dg[0] = r2_g;
    for (int k = 0; k < L - 1; k++) begin
      w_dg[k+1] = w_dg[k];
      for (int i = (3 << (L - 2 - k)) - 1; i < WIDTH; i += (2 << (L - 2 - k))) begin
        w_dg[k+1][i] = w_dg[k][i] | (r2_gp[i] & w_dg[k][i - (1 << (L - 2 - k))]);
      end
    end
    w_c   = {w_dg[L-1], r2_cin};
    w_sum = r2_p ^ w_c[WIDTH-1:0];
  end

  // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r1_v    <= 1'b0;
      r2_v    <= 1'b0;
      r3_v    <= 1'b0;
      r3_s    <= '0;
      r3_cout <= 1'b0;
`ifdef BKA_OVF_EN
      r3_ovf  <= 1'b0;
`endif
    end else if (w_adv) begin
      r1_v <= in_valid;
      r2_v <= r1_v;
      r3_v <= r2_v;
      if (r2_v) begin
        r3_s    <= w_sum;
        r3_cout <= w_c[WIDTH];
`ifdef BKA_OVF_EN
        r3_ovf  <= w_c[WIDTH] ^ w_c[WIDTH-1];
`endif
      end
    end
  end

  // NOTE: the S1/S2 datapath has no reset; the stage valid bits qualify it.
  always_ff @(posedge clk) begin
    if (w_adv) begin
      r1_g   <= a & b;
      r1_p   <= a ^ b;
      r1_cin <= cin;
      r2_g   <= w_ug[L];
      r2_gp  <= w_up[L];
      r2_p   <= r1_p;
      r2_cin <= r1_cin;
    end
  end

  assign out_valid = r3_v;
  assign s         = r3_s;
  assign cout      = r3_cout;
`ifdef BKA_OVF_EN
  assign ovf       = r3_ovf;
`endif

endmodule

// File: doc/bka_pipe_adder.md
BKA_PIPE_ADDER -- requirements
Module: bka_pipe_adder

Interface
REQ-001 Parameter WIDTH, default 16: operand width; SHALL be a power of two in the range 4..64.
REQ-002 Port clk  input  1: sole clock; all state updates on the rising edge.
REQ-003 Port rst  input  1: reset, asynchronous and active-high.
REQ-004 Port in_valid  input  1: a, b and cin carry a valid operation.
REQ-005 Port in_ready  output  1: the adder can accept an operation this cycle.
REQ-006 Ports a, b  input  WIDTH each: operands, unsigned or two's complement.
REQ-007 Port cin  input  1: carry-in.
REQ-008 Port out_valid  output  1: s, cout and ovf hold a valid result.
REQ-009 Port out_ready  input  1: the consumer accepts the result this cycle.
REQ-010 Port s  output  WIDTH: sum.
REQ-011 Port cout  output  1: carry-out of bit WIDTH-1.
REQ-012 Port ovf  output  1: signed overflow; present only when BKA_OVF_EN is defined.

Function
REQ-013 An operation SHALL be accepted on any rising edge where in_valid=1 and in_ready=1.
REQ-014 The adder SHALL have three register stages:
- S1 registers bitwise g=a&b, p=a^b and cin.
- S2 registers the Brent-Kung up-sweep group (G,P) terms.
- S3 registers the down-sweep carries and the final sum.
REQ-015 Latency SHALL be exactly 3 cycles from acceptance to out_valid=1 when the pipeline is not stalled.
REQ-016 Throughput SHALL be one operation per cycle while out_ready=1.
REQ-017 The result SHALL satisfy {cout,s} = a + b + cin, computed modulo 2^(WIDTH+1).
REQ-018 Carries SHALL come from a Brent-Kung parallel-prefix tree of 2*log2(WIDTH)-1 levels; ripple-carry and behavioural "+" are not permitted.
REQ-019 Each stage SHALL carry a valid bit; bubbles (invalid slots) SHALL propagate and never reach out_valid.
REQ-020 Stall: while out_valid=1 and out_ready=0, every stage SHALL hold, s/cout/ovf/out_valid SHALL stay stable, and in_ready=0.
REQ-021 In all other cycles in_ready SHALL be 1, including when out_valid=0 regardless of out_ready.
REQ-022 Boundary:
- Inputs SHALL be ignored while in_ready=0.
- If out_ready rises while in_valid=1, that operation SHALL be accepted in the same cycle the held result is consumed.
REQ-023 Boundary: all-ones + all-ones with cin=1 SHALL give s=all-ones, cout=1.

Reset
REQ-024 Asserting rst SHALL immediately clear all stage valid bits, with out_valid=0, s=0, cout=0 and ovf=0.
REQ-025 Operations in flight when rst asserts SHALL be discarded and never emitted.
REQ-026 After rst deasserts, in_ready SHALL be 1 and the first accepted operation SHALL appear 3 cycles later.

Configuration
REQ-027 Macro BKA_OVF_EN:
- Defined: ovf SHALL equal the carry into bit WIDTH-1 XOR cout, and SHALL be pipelined and stalled with s.
- Undefined: the ovf port and its logic SHALL be absent, and all other behaviour SHALL be unchanged.

Verification (WIDTH=16)
REQ-028 a=0x0001, b=0xFFFF, cin=0 -> 3 cycles later s=0x0000, cout=1, ovf=0.
REQ-029 a=0x7FFF, b=0x0001, cin=0 with BKA_OVF_EN defined -> s=0x8000, cout=0, ovf=1.
REQ-030 Ten back-to-back operations with out_ready=1 -> ten results on consecutive cycles starting at cycle 3, in order.
REQ-031 out_ready=0 for 4 cycles while a result is pending -> s held constant, in_ready=0, no loss or duplication after release.
REQ-032 rst pulsed with 2 operations in flight -> out_valid=0 immediately, neither result ever appears.
REQ-033 a=0xFFFF, b=0xFFFF, cin=1 -> s=0xFFFF, cout=1; randomized 1000 operations match a+b+cin.
